rtype_issuer: RTL and testbench
===============================

# rtype_issuer

Instruction-issue front end for the R-type RISC-V core. It accepts decoded operation requests (operation, rd, rs1, rs2) over a valid/ready handshake and encodes each into a 32-bit RV32 R-type instruction word. Encoded words are buffered in a small FIFO and presented one per cycle on the core's `instruction` input. A read-after-write interlock inserts NOP bubbles so that each instruction sees register-file data already written back.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, minimum 2.
- `HAZARD_GAP`, 1: bubble window after a producer, in cycles; legal range 1..3.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request may be accepted; equals (`level` < `DEPTH`).
- `req_op` in 4: operation code. 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Codes 10–15 are illegal.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register addresses.
- `stall_in` in 1: the core holds; all issue-side state freezes.
- `instruction` out 32: registered instruction word sent to the core.
- `instr_valid` out 1: registered; high when `instruction` is a real request rather than a bubble.
- `illegal_op` out 1: registered one-cycle pulse when an illegal request is dropped.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
**Request acceptance**
- A request is accepted on a rising edge where `req_valid` and `req_ready` are both high.
- There is no full-bypass: when `level` is `DEPTH`, `req_ready` is low, even if a pop occurs in the same cycle.

**Encoding** (performed at accept time; the FIFO stores encoded words)
- Word layout: `instruction` = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
- funct3 values: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- funct7 is 0100000 for SUB and SRA, and 0000000 for all other operations.

**Illegal operation codes**
- The request is accepted (`req_ready` obeyed) but not written to the FIFO.
- `illegal_op` pulses for one cycle after the accepting edge.

**Issue** (every edge with `stall_in` low)
- If the FIFO is non-empty and there is no hazard: pop the head into `instruction` and set `instr_valid` to 1.
- Otherwise: load NOP 0x00000033 (ADD x0,x0,x0) and set `instr_valid` to 0.

**Stall**
- While `stall_in` is high: no pop, `instruction` and `instr_valid` hold, and the hazard history holds.
- Pushes continue during stall.

**Hazard history**
- A shift register `HAZARD_GAP` deep holds the rd of each issue slot. Bubbles and rd=x0 are recorded as 0.
- It shifts on every non-stalled edge.
- A hazard exists when any nonzero history entry equals the head's rs1 or rs2.

**Simultaneous push and pop**
- Both occur; `level` is unchanged.

**Push into an empty FIFO**
- The pushed word is not issuable on the same edge.

## Timing
- **Reset values:**
  - `instruction` = 0x00000033.
  - `instr_valid`, `illegal_op` = 0.
  - `level` = 0, so `req_ready` = 1.
  - Hazard history all 0.
  - FIFO pointers = 0.
- **Reset mid-operation:** queued requests are discarded and the in-flight output reverts to NOP asynchronously.
- **Latency:** a request accepted at edge N appears on `instruction` after edge N+1 at the earliest (no hazard, no stall).
- **Throughput:** one instruction per cycle for independent operations.
- **Dependent pair:** a consumer that follows its producer gets exactly `HAZARD_GAP` bubbles between them.
- **Pointer arithmetic:** read and write pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.

## Configuration
- Macro: `RTYPE_ISSUE_HAZARD_EN`.
- **Defined:** hazard history and interlock are present as described above.
- **Undefined:** the history registers are absent, the hazard term is constant 0, and the head issues whenever the FIFO is non-empty and `stall_in` is low.

## Structure
- Package `rtype_issue_pkg` holds:
  - the operation enum (4-bit);
  - funct3 and funct7 constants;
  - `OPCODE_OP` = 7'b0110011;
  - `NOP_INSTR` = 32'h00000033.
- Sub-module `rtype_encoder`: combinational mapping from op/rd/rs1/rs2 to a 32-bit word plus an `illegal` flag. It is instantiated on the push path.

## Test plan
1. **ADD:** push ADD rd=3, rs1=1, rs2=2 into an empty FIFO → after the second edge, `instruction` = 0x002081B3 and `instr_valid` = 1.
2. **SUB, SRA, AND back-to-back:** push SUB x5,x6,x7; SRA x1,x2,x3; AND x4,x4,x4 (independent) → 0x407302B3, 0x403150B3, 0x00427233 on consecutive cycles with no bubbles.
3. **RAW hazard:** with `HAZARD_GAP` = 1 and the macro defined, push ADD x3,x1,x2 then XOR x4,x3,x1 → 0x002081B3, one NOP with `instr_valid` = 0, then 0x0011C233. With the macro undefined → no NOP.
4. **Full FIFO:** fill to `DEPTH` = 4 with `stall_in` = 1 → `req_ready` = 0 and `level` = 4. Release the stall → one pop per cycle and `req_ready` returns to 1 after the first pop.
5. **Illegal op:** push op = 12 → `illegal_op` pulses once, `level` is unchanged, and the output stays NOP.
6. **Reset mid-operation:** assert `rst` low mid-stream with 3 entries queued → `instruction` = 0x00000033, `instr_valid` = 0 and `level` = 0 immediately, and no stale words issue after release.

Source files
------------

// File: rtl/rtype_issuer_pkg.sv
// rtype_issue_pkg: shared operation codes, funct fields and fixed words
// for the R-type issue front end.
package rtype_issue_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLTU = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_OR   = 4'd8,
      OP_AND  = 4'd9
   } op_e;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [6:0]  OPCODE_OP = 7'b0110011;
   localparam logic [31:0] NOP_INSTR = 32'h00000033;

endpackage

// File: rtl/rtype_issuer_if.sv
// Request handshake and core-side issue signals of rtype_issuer.
interface rtype_issuer_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [4:0]    req_rd;
   logic [4:0]    req_rs1;
   logic [4:0]    req_rs2;
   logic          stall_in;
   logic [31:0]   instruction;
   logic          instr_valid;
   logic          illegal_op;
   logic [LW-1:0] level;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, stall_in,
      input  req_ready, instruction, instr_valid, illegal_op, level
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, stall_in,
      output req_ready, instruction, instr_valid, illegal_op, level
   );

endinterface

// File: rtl/rtype_issuer_encoder.sv
// rtype_encoder: op/rd/rs1/rs2 to an RV32 R-type word, flags codes 10-15.
module rtype_encoder
   import rtype_issue_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   logic [2:0] f3;
   logic [6:0] f7;

   always_comb begin
      f3        = F3_ADD;
      f7        = F7_BASE;
      illegal_o = 1'b0;
      case (op_i)
         OP_ADD:  f3 = F3_ADD;
         OP_SUB:  begin f3 = F3_ADD; f7 = F7_ALT; end
         OP_SLL:  f3 = F3_SLL;
         OP_SLT:  f3 = F3_SLT;
         OP_SLTU: f3 = F3_SLTU;
         OP_XOR:  f3 = F3_XOR;
         OP_SRL:  f3 = F3_SR;
         OP_SRA:  begin f3 = F3_SR; f7 = F7_ALT; end
         OP_OR:   f3 = F3_OR;
         OP_AND:  f3 = F3_AND;
         default: illegal_o = 1'b1;
      endcase
   end

   assign word_o = {f7, rs2_i, rs1_i, f3, rd_i, OPCODE_OP};

endmodule

// File: rtl/rtype_issuer.sv
// rtype_issuer: encode requests into a FIFO and issue one word per cycle.
// RTYPE_ISSUE_HAZARD_EN enables the read-after-write bubble interlock.
module rtype_issuer
   import rtype_issue_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int HAZARD_GAP = 1
) (
   input logic           clk,
   input logic           rst,
   rtype_issuer_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [LW-1:0] level_q, level_d;
   logic [31:0]   instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          illegal_q;

   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        accept, push, pop, hazard;
   logic [31:0] head;

   rtype_encoder u_enc (
      .op_i      (bus.req_op),
      .rd_i      (bus.req_rd),
      .rs1_i     (bus.req_rs1),
      .rs2_i     (bus.req_rs2),
      .word_o    (enc_word),
      .illegal_o (enc_illegal)
   );

   assign bus.req_ready = (level_q < LW'(DEPTH));
   assign accept        = bus.req_valid & bus.req_ready;
   assign push          = accept & ~enc_illegal;
   assign head          = mem_q[rptr_q];
   assign pop           = ~bus.stall_in & (level_q != '0) & ~hazard;

`ifdef RTYPE_ISSUE_HAZARD_EN
   logic [4:0]            hist_q [HAZARD_GAP];
   logic [HAZARD_GAP-1:0] hit;

   always_comb begin
      hit = '0;
      for (int i = 0; i < HAZARD_GAP; i++)
         hit[i] = (hist_q[i] != 5'd0) &&
                  ((hist_q[i] == head[19:15]) ||
                   (hist_q[i] == head[24:20]));
   end

   assign hazard = |hit;

   // Bubbles shift in x0, so they never match a source register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < HAZARD_GAP; i++)
            hist_q[i] <= 5'd0;
      end else if (!bus.stall_in) begin
         hist_q[0] <= pop ? head[11:7] : 5'd0;
         for (int i = 1; i < HAZARD_GAP; i++)
            hist_q[i] <= hist_q[i-1];
      end
   end
`else
   assign hazard = 1'b0;
`endif

   always_comb begin
      level_d = level_q + LW'(push) - LW'(pop);
      instr_d = instr_q;
      valid_d = valid_q;
      if (!bus.stall_in) begin
         instr_d = pop ? head : NOP_INSTR;
         valid_d = pop;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wptr_q] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         instr_q   <= NOP_INSTR;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         if (push)
            wptr_q <= wptr_q + AW'(1);
         if (pop)
            rptr_q <= rptr_q + AW'(1);
         level_q   <= level_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         illegal_q <= accept & enc_illegal;
      end
   end

   assign bus.instruction = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.illegal_op  = illegal_q;
   assign bus.level       = level_q;

endmodule

// File: tb/tb_rtype_issuer.sv
// tb_rtype_issuer: directed and random stimulus against a queue model.
module tb_rtype_issuer;

   localparam int DEPTH = 4;
   localparam int GAP   = 1;
   localparam logic [31:0] NOP = 32'h00000033;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rtype_issuer_if #(.DEPTH(DEPTH)) bus ();

   rtype_issuer #(
      .DEPTH      (DEPTH),
      .HAZARD_GAP (GAP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mq [$];
   logic [4:0]  mhist [$];
   logic [31:0] m_instr;
   logic        m_valid;
   logic        m_ill;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int op, input int rd,
                                       input int rs1, input int rs2);
      logic [2:0] f3;
      logic [6:0] f7;
      logic [4:0] a, b, c;
      a  = rd[4:0];
      b  = rs1[4:0];
      c  = rs2[4:0];
      f7 = (op == 1 || op == 7) ? 7'b0100000 : 7'b0000000;
      case (op)
         0, 1:    f3 = 3'd0;
         2:       f3 = 3'd1;
         3:       f3 = 3'd2;
         4:       f3 = 3'd3;
         5:       f3 = 3'd4;
         6, 7:    f3 = 3'd5;
         8:       f3 = 3'd6;
         default: f3 = 3'd7;
      endcase
      return {f7, c, b, f3, a, 7'b0110011};
   endfunction

   function automatic bit blocked(input logic [31:0] w);
`ifdef RTYPE_ISSUE_HAZARD_EN
      foreach (mhist[i])
         if (mhist[i] != 5'd0 &&
             (mhist[i] == w[19:15] || mhist[i] == w[24:20]))
            return 1'b1;
`endif
      return 1'b0;
   endfunction

   task automatic model_reset();
      mq.delete();
      mhist.delete();
      for (int i = 0; i < GAP; i++) mhist.push_back(5'd0);
      m_instr = NOP;
      m_valid = 1'b0;
      m_ill   = 1'b0;
   endtask

   task automatic step(input bit v, input int op, input int rd,
                       input int rs1, input int rs2, input bit stall);
      bit          acc;
      logic [31:0] w;
      logic [4:0]  nrd;
      @(negedge clk);
      bus.req_valid = v;
      bus.req_op    = op[3:0];
      bus.req_rd    = rd[4:0];
      bus.req_rs1   = rs1[4:0];
      bus.req_rs2   = rs2[4:0];
      bus.stall_in  = stall;
      #1;
      check("req_ready", {31'd0, bus.req_ready},
            {31'd0, mq.size() < DEPTH});
      acc = v && (mq.size() < DEPTH);
      if (!stall) begin
         nrd = 5'd0;
         if (mq.size() > 0 && !blocked(mq[0])) begin
            w       = mq.pop_front();
            m_instr = w;
            m_valid = 1'b1;
            nrd     = w[11:7];
         end else begin
            m_instr = NOP;
            m_valid = 1'b0;
         end
         mhist.push_front(nrd);
         void'(mhist.pop_back());
      end
      if (acc && op < 10) mq.push_back(enc(op, rd, rs1, rs2));
      m_ill = acc && (op >= 10);
      @(posedge clk);
      #1;
      check("instruction", bus.instruction, m_instr);
      check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
      check("illegal_op", {31'd0, bus.illegal_op}, {31'd0, m_ill});
      check("level", 32'(bus.level), 32'(mq.size()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_rd    = '0;
      bus.req_rs1   = '0;
      bus.req_rs2   = '0;
      bus.stall_in  = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_instr", bus.instruction, NOP);
      check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("rst_level", 32'(bus.level), 32'd0);
      check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_ill", {31'd0, bus.illegal_op}, 32'd0);
      rst = 1'b1;

      // ADD into empty FIFO: visible after the second edge
      step(1, 0, 3, 1, 2, 0);
      step(0, 0, 0, 0, 0, 0);
      check("t1_add", bus.instruction, 32'h002081B3);
      check("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
      idle(3);

      step(1, 1, 5, 6, 7, 0);
      step(1, 7, 1, 2, 3, 0);
      check("t2_sub", bus.instruction, 32'h407302B3);
      step(1, 9, 4, 4, 4, 0);
      check("t2_sra", bus.instruction, 32'h403150B3);
      step(0, 0, 0, 0, 0, 0);
      check("t2_and", bus.instruction, 32'h00427233);
      idle(3);

      step(1, 0, 3, 1, 2, 0);
      step(1, 5, 4, 3, 1, 0);
      check("t3_add", bus.instruction, 32'h002081B3);
      step(0, 0, 0, 0, 0, 0);
`ifdef RTYPE_ISSUE_HAZARD_EN
      check("t3_bubble", bus.instruction, NOP);
      check("t3_bvalid", {31'd0, bus.instr_valid}, 32'd0);
      step(0, 0, 0, 0, 0, 0);
`endif
      check("t3_xor", bus.instruction, 32'h0011C233);
      idle(3);

      for (int i = 0; i < DEPTH + 1; i++)
         step(1, i % 10, 0, i + 1, i + 2, 1);
      check("t4_level", 32'(bus.level), DEPTH);
      check("t4_ready", {31'd0, bus.req_ready}, 32'd0);
      step(0, 0, 0, 0, 0, 0);
      check("t4_pop_lvl", 32'(bus.level), DEPTH - 1);
      check("t4_pop_rdy", {31'd0, bus.req_ready}, 32'd1);
      idle(DEPTH + 2);

      step(1, 12, 3, 1, 2, 0);
      check("t5_ill", {31'd0, bus.illegal_op}, 32'd1);
      check("t5_level", 32'(bus.level), 32'd0);
      step(0, 0, 0, 0, 0, 0);
      check("t5_ill_end", {31'd0, bus.illegal_op}, 32'd0);
      check("t5_nop", bus.instruction, NOP);

      step(1, 8, 9, 10, 11, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, i, 12 + i, 1, 2, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.stall_in  = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("t6_instr", bus.instruction, NOP);
      check("t6_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("t6_level", 32'(bus.level), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(4);

      for (int i = 0; i < 500; i++) begin
         int op;
         op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                          : int'($urandom_range(0, 9));
         step($urandom_range(0, 9) < 7, op,
              $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 4) == 0);
      end
      idle(DEPTH + GAP + 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
